// File: rtl/rb_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rb_wb_arbiter_pkg
// Shared definitions for the register-file write-port arbiter: data and
// register-address widths, default FIFO depth / starvation limit, the
// buffered write request type and a one-hot destination helper.
// ----------------------------------------------------------------------------
package rb_wb_arbiter_pkg;

   localparam int XLEN             = 32;
   localparam int AW               = 5;
   localparam int DEF_DEPTH        = 4;
   localparam int DEF_STARVE_LIMIT = 3;

   // One register-file write: destination plus data
   typedef struct packed {
      logic [AW-1:0]   waddr;
      logic [XLEN-1:0] wdata;
   } wb_req_t;

   // One-hot mask of a destination register, used by the pending scoreboard
   function automatic logic [(2**AW)-1:0] rd_onehot(input logic [AW-1:0] rd);
      logic [(2**AW)-1:0] one_v;
      one_v = {{((2**AW)-1){1'b0}}, 1'b1};
      return one_v << rd;
   endfunction

endpackage

// File: rtl/rb_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// rb_wb_arbiter_if
// Bundle of all arbiter bus signals:
//   pipe_*   : RB-stage writeback request and its ready/hold response
//   ll_*     : long-latency result push channel
//   issue_*  : long-latency issue notification (scoreboard set)
//   rf_*     : registered register-file write port
//   busy     : pending long-latency destinations
//   fifo_count : result FIFO occupancy
// master = pipeline / long-latency side, slave = arbiter.
// ----------------------------------------------------------------------------
interface rb_wb_arbiter_if
   import rb_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) ();

   localparam int CW = $clog2(DEPTH) + 1;

   logic                pipe_wen;
   logic [AW-1:0]       pipe_waddr;
   logic [XLEN-1:0]     pipe_wdata;
   logic                pipe_ready;
   logic                ll_valid;
   logic [AW-1:0]       ll_waddr;
   logic [XLEN-1:0]     ll_wdata;
   logic                ll_ready;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                rf_wen;
   logic [AW-1:0]       rf_waddr;
   logic [XLEN-1:0]     rf_wdata;
   logic [(2**AW)-1:0]  busy;
   logic [CW-1:0]       fifo_count;

   modport master (
      output pipe_wen, pipe_waddr, pipe_wdata,
      output ll_valid, ll_waddr, ll_wdata,
      output issue_valid, issue_rd,
      input  pipe_ready, ll_ready,
      input  rf_wen, rf_waddr, rf_wdata, busy, fifo_count
   );

   modport slave (
      input  pipe_wen, pipe_waddr, pipe_wdata,
      input  ll_valid, ll_waddr, ll_wdata,
      input  issue_valid, issue_rd,
      output pipe_ready, ll_ready,
      output rf_wen, rf_waddr, rf_wdata, busy, fifo_count
   );

endinterface

// File: rtl/rb_wb_arbiter_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_req_t write requests, DEPTH entries (power of 2).
// Pointers carry one extra MSB so full/empty are distinguished by the count.
// Ports: clk, rst (async active-high), push/wr_data, pop/rd_data (head,
// combinational read), count (occupancy). The caller never pushes when full
// nor pops when empty. Contents are not cleared on reset; the pointers are.
// ----------------------------------------------------------------------------
module wb_fifo
   import rb_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_req_t                wr_data,
   input  logic                   pop,
   output wb_req_t                rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   wb_req_t       mem_r [DEPTH];
   logic [PW:0]   wr_ptr_r;
   logic [PW:0]   rd_ptr_r;

   // Read/write pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(PW+1){1'b0}};
         rd_ptr_r <= {(PW+1){1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
         end
      end
   end

   // Entry storage write
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r[PW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r[PW-1:0]];
   assign count   = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/rb_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rb_wb_arbiter
// Shares the single register-file write port between the RB-stage writeback
// and buffered out-of-order long-latency results. The FIFO head drains in
// idle writeback slots; after STARVE_LIMIT consecutive losses it is forced
// through while the RB stage is held for one cycle (pipe_ready=0).
// Also tracks pending long-latency destinations (busy) for the hazard unit.
// Ports: clk, rst (async active-high), bus (rb_wb_arbiter_if.slave).
// ----------------------------------------------------------------------------
module rb_wb_arbiter
   import rb_wb_arbiter_pkg::*;
#(
   parameter int XLEN         = rb_wb_arbiter_pkg::XLEN,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic             clk,
   input  logic             rst,
   rb_wb_arbiter_if.slave   bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

   wb_req_t             head_s;
   wb_req_t             push_req_s;
   logic [CW-1:0]       count_s;
   logic                fifo_empty_s;
   logic                ll_ready_s;
   logic                push_s;
   logic                pipe_real_s;
   logic                fifo_grant_s;
   logic [SW-1:0]       starve_cnt_r;
   logic                rf_wen_r;
   logic [AW-1:0]       rf_waddr_r;
   logic [XLEN-1:0]     rf_wdata_r;
   logic [(2**AW)-1:0]  busy_r;
   logic [(2**AW)-1:0]  busy_nxt_s;

   // Readiness uses the pre-pop count, so a full FIFO never takes a push
   // even in a cycle where it also pops.
   assign fifo_empty_s       = (count_s == {CW{1'b0}});
   assign ll_ready_s         = !rst && (count_s < DEPTH_C);
   assign push_s             = bus.ll_valid && ll_ready_s && (bus.ll_waddr != {AW{1'b0}});
   assign push_req_s.waddr   = bus.ll_waddr;
   assign push_req_s.wdata   = bus.ll_wdata;
   assign pipe_real_s        = bus.pipe_wen && (bus.pipe_waddr != {AW{1'b0}});
   assign fifo_grant_s       = !fifo_empty_s && (!pipe_real_s || (starve_cnt_r == LIMIT_C));

   wb_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_s),
      .wr_data (push_req_s),
      .pop     (fifo_grant_s),
      .rd_data (head_s),
      .count   (count_s)
   );

   // Consecutive arbitration losses of a waiting FIFO head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= {SW{1'b0}};
      end else if (fifo_empty_s || fifo_grant_s) begin
         starve_cnt_r <= {SW{1'b0}};
      end else if (starve_cnt_r != LIMIT_C) begin
         starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Registered register-file write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wen_r   <= 1'b0;
         rf_waddr_r <= {AW{1'b0}};
         rf_wdata_r <= {XLEN{1'b0}};
      end else if (fifo_grant_s) begin
         rf_wen_r   <= 1'b1;
         rf_waddr_r <= head_s.waddr;
         rf_wdata_r <= head_s.wdata;
      end else if (pipe_real_s) begin
         rf_wen_r   <= 1'b1;
         rf_waddr_r <= bus.pipe_waddr;
         rf_wdata_r <= bus.pipe_wdata;
      end else begin
         rf_wen_r   <= 1'b0;
      end
   end

   // Scoreboard next state: grant clears, issue sets (set wins), x0 never busy
   always_comb begin
      busy_nxt_s = busy_r;
      if (fifo_grant_s) begin
         busy_nxt_s = busy_nxt_s & ~rd_onehot(head_s.waddr);
      end else begin
         busy_nxt_s = busy_r;
      end
      if (bus.issue_valid && (bus.issue_rd != {AW{1'b0}})) begin
         busy_nxt_s = busy_nxt_s | rd_onehot(bus.issue_rd);
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= {(2**AW){1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign bus.pipe_ready = !(fifo_grant_s && pipe_real_s);
   assign bus.ll_ready   = ll_ready_s;
   assign bus.rf_wen     = rf_wen_r;
   assign bus.rf_waddr   = rf_waddr_r;
   assign bus.rf_wdata   = rf_wdata_r;
   assign bus.busy       = busy_r;
   assign bus.fifo_count = count_s;

endmodule
